// File: rtl/vlm_speech_sequencer_pkg.sv
// Shared types and default constants for the VLM5030 speech sequencer.
package vlm_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        ST_HI     = 3'd2,
        WAIT_RISE = 3'd3,
        PLAY      = 3'd4
    } seq_state_e;

    localparam int unsigned DEF_QDEPTH    = 4;
    localparam int unsigned DEF_ST_CYCLES = 8;
    localparam int unsigned DEF_TO_W      = 16;

endpackage

// File: rtl/vlm_speech_sequencer_if.sv
// Request / VLM pin bundle between the sound CPU decode side (master) and the sequencer (slave).
interface vlm_speech_sequencer_if
    import vlm_seq_pkg::*;
#(
    parameter int unsigned QDEPTH = DEF_QDEPTH
);
    logic                      req_valid;
    logic [7:0]                req_phrase;
    logic                      req_ready;
    logic                      flush;
    logic [7:0]                vlm_data;
    logic                      vlm_st;
    logic                      vlm_bsy;
    logic                      busy;
    logic [$clog2(QDEPTH):0]   qcount;
    logic                      timeout_err;

    modport master (
        output req_valid, req_phrase, flush, vlm_bsy,
        input  req_ready, vlm_data, vlm_st, busy, qcount, timeout_err
    );

    modport slave (
        input  req_valid, req_phrase, flush, vlm_bsy,
        output req_ready, vlm_data, vlm_st, busy, qcount, timeout_err
    );
endinterface

// File: rtl/vlm_speech_sequencer_req_fifo.sv
// Phrase request FIFO: power-of-two depth, flush beats push, pointers wrap naturally.
module vlm_req_fifo #(
    parameter int unsigned QDEPTH = 4,
    parameter int unsigned W      = 8
) (
    input  logic                      CPUCL,
    input  logic                      reset,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic                      flush_i,
    input  logic [W-1:0]              wdata_i,
    output logic [W-1:0]              rdata_o,
    output logic [$clog2(QDEPTH):0]   count_o,
    output logic [$clog2(QDEPTH):0]   count_nxt_o,
    output logic                      full_o,
    output logic                      empty_o
);
    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem [QDEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == CW'(QDEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign rdata_o = mem[rd_q];
    assign count_o = count_q;

    always_comb begin
        count_nxt_o = count_q + CW'(push_ok) - CW'(pop_ok);
        if (flush_i) count_nxt_o = '0;
    end

    always_ff @(posedge CPUCL or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_q + PW'(push_ok);
            rd_q    <= rd_q + PW'(pop_ok);
            count_q <= count_nxt_o;
        end
    end

    always_ff @(posedge CPUCL) begin
        if (push_ok & ~flush_i) mem[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/vlm_speech_sequencer.sv
// VLM5030 phrase sequencer: queues requests, drives data latch + ST pulse, tracks BSY.
// Optional BSY-wait timeout enabled by defining VLM_SEQ_TIMEOUT_EN.
module vlm_speech_sequencer
    import vlm_seq_pkg::*;
#(
    parameter int unsigned QDEPTH    = DEF_QDEPTH,
    parameter int unsigned ST_CYCLES = DEF_ST_CYCLES,
    parameter int unsigned TO_W      = DEF_TO_W
) (
    input  logic                  CPUCL,
    input  logic                  reset,
    vlm_speech_sequencer_if.slave bus
);
    localparam int unsigned CW      = $clog2(QDEPTH) + 1;
    localparam logic [7:0]  ST_LOAD = 8'(ST_CYCLES - 1);

    if ((QDEPTH < 2) || (QDEPTH > 16) || ((QDEPTH & (QDEPTH - 1)) != 0)) begin : g_bad_qdepth
        $error("vlm_speech_sequencer: QDEPTH must be a power of two in 2..16");
    end
    if ((ST_CYCLES < 1) || (ST_CYCLES > 255)) begin : g_bad_st
        $error("vlm_speech_sequencer: ST_CYCLES must be 1..255");
    end
    if ((TO_W < 2) || (TO_W > 32)) begin : g_bad_tow
        $error("vlm_speech_sequencer: TO_W must be 2..32");
    end

    seq_state_e    state_q;
    logic [7:0]    data_q;
    logic          st_q;
    logic [7:0]    st_cnt_q;
    logic          busy_q, busy_d;
    logic          bsy_meta_q, bsy_s_q;
    logic          to_fire;
    logic          timeout_err_q;

    logic [CW-1:0] count, count_nxt;
    logic          full, empty, push, pop;
    logic [7:0]    head;

    assign push = bus.req_valid & ~full;
    assign pop  = (state_q == IDLE) & ~empty;

    vlm_req_fifo #(
        .QDEPTH (QDEPTH),
        .W      (8)
    ) u_fifo (
        .CPUCL       (CPUCL),
        .reset       (reset),
        .push_i      (push),
        .pop_i       (pop),
        .flush_i     (bus.flush),
        .wdata_i     (bus.req_phrase),
        .rdata_o     (head),
        .count_o     (count),
        .count_nxt_o (count_nxt),
        .full_o      (full),
        .empty_o     (empty)
    );

    always_ff @(posedge CPUCL or posedge reset) begin
        if (reset) begin
            bsy_meta_q <= 1'b0;
            bsy_s_q    <= 1'b0;
        end else begin
            bsy_meta_q <= bus.vlm_bsy;
            bsy_s_q    <= bsy_meta_q;
        end
    end

    // busy is registered from next-state values so it tracks pushes and the return to IDLE on the same edge
    always_comb begin
        busy_d = (count_nxt != '0) |
                 ~(((state_q == IDLE) & empty) | ((state_q == PLAY) & ~bsy_s_q) | to_fire);
    end

`ifdef VLM_SEQ_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};
    logic [TO_W-1:0] to_cnt_q;

    // fires on the edge where the count would reach all-ones
    assign to_fire = (to_cnt_q == TO_LAST) &
                     (((state_q == WAIT_RISE) & ~bsy_s_q) | ((state_q == PLAY) & bsy_s_q));

    always_ff @(posedge CPUCL or posedge reset) begin
        if (reset) begin
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (((state_q == ST_HI) & (st_cnt_q == '0)) | ((state_q == WAIT_RISE) & bsy_s_q) | to_fire)
                to_cnt_q <= '0;
            else if ((state_q == WAIT_RISE) | (state_q == PLAY))
                to_cnt_q <= to_cnt_q + 1'b1;

            if (to_fire)   timeout_err_q <= 1'b1;
            else if (push) timeout_err_q <= 1'b0;
        end
    end
`else
    assign to_fire       = 1'b0;
    assign timeout_err_q = 1'b0;
`endif

    always_ff @(posedge CPUCL or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            data_q   <= '0;
            st_q     <= 1'b0;
            st_cnt_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            busy_q <= busy_d;
            unique case (state_q)
                IDLE: begin
                    if (!empty) begin
                        data_q  <= head;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    st_q     <= 1'b1;
                    st_cnt_q <= ST_LOAD;
                    state_q  <= ST_HI;
                end
                ST_HI: begin
                    if (st_cnt_q == '0) begin
                        st_q    <= 1'b0;
                        state_q <= WAIT_RISE;
                    end else begin
                        st_cnt_q <= st_cnt_q - 1'b1;
                    end
                end
                WAIT_RISE: begin
                    if (bsy_s_q) begin
                        state_q <= PLAY;
                    end else if (to_fire) begin
                        st_q    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                PLAY: begin
                    if (!bsy_s_q) begin
                        state_q <= IDLE;
                    end else if (to_fire) begin
                        st_q    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready   = ~full;
    assign bus.vlm_data    = data_q;
    assign bus.vlm_st      = st_q;
    assign bus.busy        = busy_q;
    assign bus.qcount      = count;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_vlm_speech_sequencer.sv
// Directed self-checking bench for vlm_speech_sequencer (timeout steps need VLM_SEQ_TIMEOUT_EN).
module tb_vlm_speech_sequencer;

`ifdef VLM_SEQ_TIMEOUT_EN
    localparam int unsigned TB_TO_W = 8;
`else
    localparam int unsigned TB_TO_W = 16;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vlm_speech_sequencer_if #(.QDEPTH(4)) bus ();

    vlm_speech_sequencer #(
        .QDEPTH    (4),
        .ST_CYCLES (8),
        .TO_W      (TB_TO_W)
    ) dut (
        .CPUCL (clk),
        .reset (rst),
        .bus   (bus)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned st_rises = 0;
    logic [7:0]  played[$];

    logic        model_en = 1'b0;
    int unsigned rise_dly = 10;
    int unsigned hold_len = 100;
    logic        bsy_model = 1'b0;
    logic        bsy_glitch = 1'b0;
    assign bus.vlm_bsy = bsy_model | bsy_glitch;

    // BSY model: rises rise_dly cycles after ST falls, stays high hold_len cycles
    initial forever begin
        @(negedge bus.vlm_st);
        if (model_en) begin
            repeat (rise_dly) @(posedge clk);
            #3 bsy_model = 1'b1;
            repeat (hold_len) @(posedge clk);
            #3 bsy_model = 1'b0;
        end
    end

    always @(posedge bus.vlm_st) begin
        st_rises++;
        played.push_back(bus.vlm_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] p);
        bus.req_valid  = 1'b1;
        bus.req_phrase = p;
        tick(1);
        bus.req_valid  = 1'b0;
    endtask

    task automatic wait_st(input logic lvl, input int unsigned lim, input string tag);
        int unsigned n = 0;
        while (bus.vlm_st !== lvl && n < lim) begin
            tick(1);
            n++;
        end
        check(tag, 32'(bus.vlm_st), 32'(lvl));
    endtask

    task automatic wait_idle(input int unsigned lim, input string tag);
        int unsigned n = 0;
        while (bus.busy !== 1'b0 && n < lim) begin
            tick(1);
            n++;
        end
        check(tag, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int unsigned hi;
        int unsigned n;
        int unsigned base;

        bus.req_valid  = 1'b0;
        bus.req_phrase = '0;
        bus.flush      = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);

        check("rst_data",    32'(bus.vlm_data),    32'h00);
        check("rst_st",      32'(bus.vlm_st),      32'd0);
        check("rst_busy",    32'(bus.busy),        32'd0);
        check("rst_qcount",  32'(bus.qcount),      32'd0);
        check("rst_ready",   32'(bus.req_ready),   32'd1);
        check("rst_timeout", 32'(bus.timeout_err), 32'd0);

        // 1: single phrase, latency and ST width, busy tail after BSY falls
        model_en = 1'b1; rise_dly = 10; hold_len = 100;
        played.delete();
        push(8'h15);
        check("t1_busy_after_push", 32'(bus.busy),   32'd1);
        check("t1_qcount_push",     32'(bus.qcount), 32'd1);
        check("t1_st_not_yet",      32'(bus.vlm_st), 32'd0);
        tick(1);
        check("t1_data_pop",        32'(bus.vlm_data), 32'h15);
        check("t1_st_still_low",    32'(bus.vlm_st),   32'd0);
        check("t1_qcount_pop",      32'(bus.qcount),   32'd0);
        tick(1);
        check("t1_st_rise",         32'(bus.vlm_st),   32'd1);
        hi = 0;
        while (bus.vlm_st === 1'b1 && hi < 300) begin
            hi++;
            tick(1);
        end
        check("t1_st_width", hi, 32'd8);
        n = 0;
        while (bus.vlm_bsy !== 1'b1 && n < 50) begin tick(1); n++; end
        check("t1_busy_in_play", 32'(bus.busy), 32'd1);
        n = 0;
        while (bus.vlm_bsy !== 1'b0 && n < 200) begin tick(1); n++; end
        tick(2);
        check("t1_busy_tail_2", 32'(bus.busy), 32'd1);
        tick(1);
        check("t1_busy_drop_3", 32'(bus.busy),     32'd0);
        check("t1_data_kept",   32'(bus.vlm_data), 32'h15);
        check("t1_played",      32'(played.size()), 32'd1);

        // 2: back-to-back pushes fill the FIFO; extra push is ignored
        rise_dly = 3; hold_len = 20;
        played.delete();
        bus.req_valid = 1'b1;
        bus.req_phrase = 8'h01; tick(1);
        check("t2_q_after_1", 32'(bus.qcount), 32'd1);
        bus.req_phrase = 8'h02; tick(1);
        check("t2_q_pushpop", 32'(bus.qcount), 32'd1);
        bus.req_phrase = 8'h03; tick(1);
        bus.req_phrase = 8'h04; tick(1);
        bus.req_phrase = 8'h05; tick(1);
        check("t2_q_full",     32'(bus.qcount),    32'd4);
        check("t2_ready_low",  32'(bus.req_ready), 32'd0);
        bus.req_phrase = 8'h06; tick(1);
        bus.req_valid = 1'b0;
        check("t2_q_ignored",  32'(bus.qcount),    32'd4);
        wait_idle(3000, "t2_drain");
        check("t2_count", 32'(played.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < played.size()) check("t2_order", 32'(played[i]), 32'(i + 1));

        // 3: flush during an active phrase (flush beats a concurrent push)
        played.delete();
        base = st_rises;
        push(8'hA0);
        wait_st(1'b1, 10, "t3_st_rise");
        bus.req_valid = 1'b1;
        bus.req_phrase = 8'hA1; tick(1);
        bus.req_phrase = 8'hA2; tick(1);
        bus.req_phrase = 8'hA3; tick(1);
        bus.req_valid = 1'b0;
        check("t3_q_3", 32'(bus.qcount), 32'd3);
        bus.flush = 1'b1; bus.req_valid = 1'b1; bus.req_phrase = 8'hA4;
        tick(1);
        bus.flush = 1'b0; bus.req_valid = 1'b0;
        check("t3_q_flushed", 32'(bus.qcount),    32'd0);
        check("t3_ready",     32'(bus.req_ready), 32'd1);
        check("t3_st_kept",   32'(bus.vlm_st),    32'd1);
        wait_idle(500, "t3_done");
        tick(20);
        check("t3_one_pulse", st_rises - base, 32'd1);
        check("t3_data",      32'(bus.vlm_data), 32'hA0);

        // 6: one-cycle BSY glitch right after ST falls
        model_en = 1'b0;
        base = st_rises;
        push(8'h66);
        wait_st(1'b1, 10, "t6_st_rise");
        wait_st(1'b0, 20, "t6_st_fall");
        bsy_glitch = 1'b1;
        tick(1);
        bsy_glitch = 1'b0;
        tick(2);
        check("t6_busy_play", 32'(bus.busy), 32'd1);
        tick(1);
        check("t6_idle", 32'(bus.busy), 32'd0);
        tick(20);
        check("t6_one_pulse", st_rises - base, 32'd1);
        check("t6_st_low",    32'(bus.vlm_st), 32'd0);

`ifdef VLM_SEQ_TIMEOUT_EN
        // 4: BSY never rises; timeout after 255 cycles in WAIT_RISE
        model_en = 1'b0;
        push(8'h44);
        wait_st(1'b1, 10, "t4_st_rise");
        wait_st(1'b0, 20, "t4_st_fall");
        n = 0;
        while (bus.timeout_err !== 1'b1 && n < 400) begin tick(1); n++; end
        check("t4_to_cycles", n, 32'd255);
        check("t4_to_flag",   32'(bus.timeout_err), 32'd1);
        check("t4_idle",      32'(bus.busy),        32'd0);
        model_en = 1'b1; rise_dly = 3; hold_len = 10;
        played.delete();
        push(8'h45);
        check("t4_to_cleared", 32'(bus.timeout_err), 32'd0);
        wait_idle(300, "t4_replay_done");
        check("t4_replayed", 32'(played.size()), 32'd1);
        check("t4_data",     32'(bus.vlm_data),  32'h45);
        check("t4_no_to",    32'(bus.timeout_err), 32'd0);
        model_en = 1'b0;
`endif

        // 5: asynchronous reset while in ST_HI
        model_en = 1'b0;
        push(8'h55);
        push(8'h56);
        wait_st(1'b1, 10, "t5_st_rise");
        tick(2);
        check("t5_q_pending", 32'(bus.qcount), 32'd1);
        check("t5_st_hi",     32'(bus.vlm_st), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_st",    32'(bus.vlm_st),    32'd0);
        check("t5_rst_busy",  32'(bus.busy),      32'd0);
        check("t5_rst_q",     32'(bus.qcount),    32'd0);
        check("t5_rst_data",  32'(bus.vlm_data),  32'h00);
        check("t5_rst_ready", 32'(bus.req_ready), 32'd1);
        tick(1);
        rst = 1'b0;
        tick(3);
        check("t5_after_st",   32'(bus.vlm_st), 32'd0);
        check("t5_after_busy", 32'(bus.busy),   32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
